// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core: operand timing encodings,
// multiply/divide latencies and the MDU state encoding.
package cpu_pkg;

    localparam logic [1:0] TUSE_NONE  = 2'd3;
    localparam logic [1:0] TNEW_READY = 2'd0;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int CNT_W_DEF    = 4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_timer.sv
// Multiply/divide busy timer: a down-counter loaded when a mult/div leaves E,
// flagging busy while HI/LO are not yet valid and pulsing done on the last cycle.
module md_timer
    import cpu_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    output logic busy,
    output logic done
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                // Division takes priority if both classes are flagged together.
                if (start_div) begin
                    cnt_d   = CNT_W'(DIV_CYC);
                    state_d = MD_BUSY;
                end else if (start_mult) begin
                    cnt_d   = CNT_W'(MULT_CYC);
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == MD_BUSY);
    assign done = (state_q == MD_BUSY) && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/stall_ctrl.sv
// Hazard and stall controller: holds PC and F/D and bubbles D/E whenever the
// D instruction needs an operand not yet produced or HI/LO is still pending.
module stall_ctrl
    import cpu_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic       d_is_md,
    input  logic [4:0] e_wa,
    input  logic [4:0] m_wa,
    input  logic [1:0] e_tnew,
    input  logic [1:0] m_tnew,
    input  logic       e_start_mult,
    input  logic       e_start_div,
    output logic       pc_we,
    output logic       fd_we,
    output logic       de_clr,
    output logic       md_busy,
    output logic       md_done
);

    logic stall_rs, stall_rt, stall_md, stall;

    md_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_timer (
        .clk        (clk),
        .reset      (reset),
        .start_mult (e_start_mult),
        .start_div  (e_start_div),
        .busy       (md_busy),
        .done       (md_done)
    );

    // A stall is needed only when the producer's result arrives later than the
    // consumer's use; tuse of TUSE_NONE can never be below any tnew.
    always_comb begin
        stall_rs = (d_rs != 5'd0) &&
                   (((d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
                    ((d_rs == m_wa) && (d_tuse_rs < m_tnew)));
        stall_rt = (d_rt != 5'd0) &&
                   (((d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
                    ((d_rt == m_wa) && (d_tuse_rt < m_tnew)));
        stall_md = d_is_md && (md_busy || e_start_mult || e_start_div);
        stall    = stall_rs || stall_rt || stall_md;
    end

    assign pc_we  = !stall;
    assign fd_we  = !stall;
    assign de_clr = stall;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_wa, m_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_is_md, e_start_mult, e_start_div;
    logic       pc_we, fd_we, de_clr, md_busy, md_done;

    typedef struct {
        logic [4:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    stall_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .d_tuse_rs    (d_tuse_rs),
        .d_tuse_rt    (d_tuse_rt),
        .d_is_md      (d_is_md),
        .e_wa         (e_wa),
        .m_wa         (m_wa),
        .e_tnew       (e_tnew),
        .m_tnew       (m_tnew),
        .e_start_mult (e_start_mult),
        .e_start_div  (e_start_div),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .de_clr       (de_clr),
        .md_busy      (md_busy),
        .md_done      (md_done)
    );

    // Monitor: one comparison per queued cycle, plus the start-while-busy check.
    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] got;
        if (md_busy === 1'b1 && (e_start_mult || e_start_div)) begin
            miscompares++;
            $display("FAIL start_while_busy: md_busy=%b start_mult=%b start_div=%b, required no start", md_busy, e_start_mult, e_start_div);
        end
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {pc_we, fd_we, de_clr, md_busy, md_done};
            vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL %s: got {pc_we,fd_we,de_clr,busy,done}=%b, expected %b", e.tag, got, e.v);
            end else begin
                $display("vec %0d %s: %b ok", vectors, e.tag, got);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        d_is_md = 1'b0; e_wa = 5'd0; m_wa = 5'd0; e_tnew = 2'd0; m_tnew = 2'd0;
        e_start_mult = 1'b0; e_start_div = 1'b0;
    endtask

    task automatic expect_out(input logic s, input logic b, input logic d, input string tag);
        exp_t e;
        e.v   = {~s, ~s, s, b, d};
        e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        next_cycle();
        expect_out(0, 0, 0, "reset_state");
        reset = 1'b0;

        // Load-use on rs: producer in E, then in M, then ready.
        next_cycle(); idle();
        e_wa = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_tuse_rs = 2'd1;
        expect_out(1, 0, 0, "loaduse_e_tuse1");
        next_cycle(); idle();
        d_rs = 5'd8; d_tuse_rs = 2'd0; m_wa = 5'd8; m_tnew = 2'd1;
        expect_out(1, 0, 0, "loaduse_m_tnew1");
        next_cycle();
        m_tnew = 2'd0;
        expect_out(0, 0, 0, "loaduse_m_ready");
        next_cycle(); idle();
        d_rs = 5'd8; d_tuse_rs = 2'd1; m_wa = 5'd8; m_tnew = 2'd1;
        expect_out(0, 0, 0, "tuse_eq_tnew");

        // Boundaries: $0, tuse none, rt path, mismatched register.
        next_cycle(); idle();
        e_wa = 5'd0; e_tnew = 2'd2; d_rs = 5'd0; d_tuse_rs = 2'd0;
        expect_out(0, 0, 0, "zero_reg_filter");
        next_cycle(); idle();
        e_wa = 5'd9; e_tnew = 2'd3; d_rt = 5'd9; d_tuse_rt = 2'd3;
        expect_out(0, 0, 0, "tuse_none");
        next_cycle(); idle();
        e_wa = 5'd5; e_tnew = 2'd1; d_rt = 5'd5; d_tuse_rt = 2'd0;
        expect_out(1, 0, 0, "rt_hazard_e");
        next_cycle(); idle();
        e_wa = 5'd6; e_tnew = 2'd2; d_rt = 5'd5; d_tuse_rt = 2'd0; d_rs = 5'd7; d_tuse_rs = 2'd0;
        expect_out(0, 0, 0, "no_reg_match");

        // Mult with md instruction held in D.
        next_cycle(); idle();
        e_start_mult = 1'b1; d_is_md = 1'b1;
        expect_out(1, 0, 0, "mult_start");
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            e_start_mult = 1'b0;
            expect_out(1, 1, (i == 5), $sformatf("mult_busy_%0d", i));
        end
        next_cycle();
        expect_out(0, 0, 0, "mult_release");

        // Div and mult flagged together: div latency wins.
        next_cycle(); idle();
        e_start_mult = 1'b1; e_start_div = 1'b1; d_is_md = 1'b1;
        expect_out(1, 0, 0, "div_start");
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            e_start_mult = 1'b0; e_start_div = 1'b0;
            expect_out(1, 1, (i == 10), $sformatf("div_busy_%0d", i));
        end
        next_cycle();
        expect_out(0, 0, 0, "div_release");

        // Reset during div cycle 4 aborts without done.
        next_cycle(); idle();
        e_start_div = 1'b1; d_is_md = 1'b1;
        expect_out(1, 0, 0, "div2_start");
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            e_start_div = 1'b0;
            expect_out(1, 1, 0, $sformatf("div2_busy_%0d", i));
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        expect_out(0, 0, 0, "div_abort");
        next_cycle();
        expect_out(0, 0, 0, "div_abort_quiet");

        // Non-md instruction proceeds while MDU counts.
        next_cycle(); idle();
        e_start_mult = 1'b1;
        expect_out(0, 0, 0, "mult2_start_nomd");
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            e_start_mult = 1'b0;
            expect_out(0, 1, (i == 5), $sformatf("mult2_nomd_%0d", i));
        end
        next_cycle();
        expect_out(0, 0, 0, "mult2_idle");

        next_cycle(); idle();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. Sequences the PC register and the F/D, D/E pipeline registers: it drives the PC write-enable and F/D enable low and flushes D/E whenever the instruction in D cannot proceed. It also owns the multiply/divide busy timer, so HI/LO-dependent instructions are held in D until the MDU result exists. Sits beside the D-stage decoder; consumes Tuse/Tnew encodings from D, E and M.

## Interface
- MULT_CYC, 5, busy cycles for mult/multu
- DIV_CYC, 10, busy cycles for div/divu
- CNT_W, 4, counter width; must hold max(MULT_CYC, DIV_CYC)
- clk  in  1  system clock, all state on posedge
- reset  in  1  one clock; reset is synchronous and active-high
- d_rs, d_rt  in  5 each  source register numbers of instruction in D
- d_tuse_rs, d_tuse_rt  in  2 each  cycles until D needs operand; 3 = not used
- d_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- e_wa, m_wa  in  5 each  destination register of E / M instruction; 0 = none
- e_tnew, m_tnew  in  2 each  cycles until E / M result is available; 0 = ready
- e_start_mult, e_start_div  in  1 each  E holds a mult-class / div-class op (one-cycle, already past D)
- pc_we  out  1  PC write enable
- fd_we  out  1  F/D register enable
- de_clr  out  1  D/E register synchronous clear (insert bubble)
- md_busy  out  1  MDU computing
- md_done  out  1  one-cycle pulse, HI/LO write strobe

## Operation
- stall_rs = d_rs≠0 and ((d_rs==e_wa and d_tuse_rs < e_tnew) or (d_rs==m_wa and d_tuse_rs < m_tnew)); stall_rt identical on rt.
- stall_md = d_is_md and (md_busy or e_start_mult or e_start_div).
- stall = stall_rs or stall_rt or stall_md; pc_we = fd_we = not stall; de_clr = stall. Purely combinational from inputs and md state.
- Tuse/Tnew compare is unsigned 2-bit; tuse 3 never stalls; tnew 0 never stalls.
- MD FSM states IDLE, BUSY; down-counter cnt[CNT_W-1:0].
  - IDLE + e_start_div: cnt ← DIV_CYC, → BUSY. IDLE + e_start_mult only: cnt ← MULT_CYC, → BUSY. Both high: div wins.
  - BUSY: cnt ← cnt-1 each cycle; cnt==1: md_done=1, → IDLE next edge.
  - Start while BUSY: ignored (unreachable given stall_md); bench asserts it never occurs.
- md_busy = (state==BUSY); md_done combinational = BUSY and cnt==1.

## Timing
- Reset (sampled at posedge): state IDLE, cnt 0, md_busy 0, md_done 0; with hazard inputs idle, pc_we 1, fd_we 1, de_clr 0. Reset mid-BUSY aborts computation, no md_done.
- Start sampled at edge t0 → md_busy high for cycles t0+1 … t0+N (N = MULT_CYC or DIV_CYC), md_done high in cycle t0+N, md_busy low at t0+N+1.
- d_is_md stalls from the start cycle through cycle t0+N inclusive; D proceeds in t0+N+1, reading HI/LO already written at end of t0+N.
- Hazard stall latency 0: stall asserted same cycle the hazard is visible.

## Structure
- Shared package cpu_pkg: TUSE/TNEW encodings (TUSE_NONE=3), MULT_CYC/DIV_CYC defaults, MD state enum.
- One sub-module md_timer (FSM + counter, outputs busy/done); hazard compare stays in stall_ctrl.

## Test plan
- Load-use: e_wa=8, e_tnew=2, d_rs=8, d_tuse_rs=1 → pc_we=0, fd_we=0, de_clr=1; next cycle m_wa=8, m_tnew=1 → still stalled; then m_tnew=0 → released.
- $0 filter: e_wa=0, e_tnew=2, d_rs=0, d_tuse_rs=0 → no stall.
- Mult: e_start_mult pulse at edge t0 → md_busy cycles t0+1..t0+5, md_done only at t0+5; d_is_md=1 throughout → stalled until t0+6.
- Div with simultaneous mult: both starts high → busy exactly 10 cycles, single done pulse.
- Reset at cycle 4 of a div → md_busy 0 next cycle, no md_done, pc_we 1.
- Non-md instruction in D while BUSY with no register hazard → pc_we=1, md_busy keeps counting.
